// File: rtl/spi_io_master.sv
// spi_io_master: IO-mapped SPI master with N gated channels, 1..16 bit
// transfers, programmable SCK divider, CPOL/CPHA, LSB-first, overrun flag
// and a maskable level done interrupt.
// Optional feature macro: SPI_LOOPBACK_EN (CTRL[11] internal loopback).
module spi_io_master #(
  parameter int CHANNELS  = 3,
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                io_sel,
  input  logic [1:0]          addr,
  input  logic                IOWb,
  input  logic                IORb,
  input  logic [15:0]         bus_in,
  output logic [15:0]         bus_out,
  output logic                bus_drive,
  output logic [CHANNELS-1:0] sck,
  output logic [CHANNELS-1:0] cs_n,
  output logic                sdo,
  input  logic                sdi,
  output logic                irq
);

`ifdef SPI_LOOPBACK_EN
  localparam logic [11:0] CTRL_MASK = 12'hFFF;
`else
  localparam logic [11:0] CTRL_MASK = 12'h7FF;
`endif
  localparam logic [11:0] CTRL_RESET = 12'h007;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD} state_t;

  state_t              state_q, state_d;
  logic                iowb_q;
  logic [DIV_W-1:0]    cnt_q, cnt_d, div_q, div_d;
  logic [4:0]          edge_q, edge_d;
  logic [11:0]         ctrl_q, ctrl_d;
  logic [15:0]         tx_q, tx_d, rx_sh_q, rx_sh_d, rx_q, rx_d;
  logic                sdo_q, sdo_d, lvl_q, lvl_d;
  logic                done_q, done_d, ovr_q, ovr_d, irq_q, irq_d;
  logic [CHANNELS-1:0] cs_n_q, cs_n_d, sck_q, sck_d;

  logic        wr, busy, expire, lead, miso, lb, lsb, cpha;
  logic [3:0]  len_m1;
  logic [2:0]  ch;
  logic [15:0] tx_ld;

  // Next-state logic: register writes, divider, transfer sequencing.
  always_comb begin
    wr     = io_sel && !IOWb && iowb_q;
    busy   = (state_q != S_IDLE);
    len_m1 = ctrl_q[3:0];
    ch     = ctrl_q[6:4];
    cpha   = ctrl_q[8];
    lsb    = ctrl_q[10];
    lb     = ctrl_q[11];
    expire = (cnt_q == '0);
    lead   = ~edge_q[0];
    miso   = lb ? sdo_q : sdi;
    // MSB-first data is left-aligned so the first bit always sits at [15].
    tx_ld  = lsb ? bus_in : (bus_in << (4'd15 - len_m1));

    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    edge_d  = edge_q;
    ctrl_d  = ctrl_q;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    sdo_d   = sdo_q;
    lvl_d   = lvl_q;
    done_d  = done_q;
    ovr_d   = ovr_q;
    cs_n_d  = cs_n_q;
    sck_d   = sck_q;
    irq_d   = done_q & ctrl_q[9];

    if (busy) cnt_d = expire ? div_q : cnt_q - DIV_W'(1);

    // Clears come before the FSM so a same-cycle DONE set wins.
    if (wr) begin
      case (addr)
        2'd0: if (busy) ovr_d = 1'b1;
        2'd1: if (busy) ovr_d = 1'b1; else ctrl_d = bus_in[11:0] & CTRL_MASK;
        2'd2: if (busy) ovr_d = 1'b1; else div_d = bus_in[DIV_W-1:0];
        default: begin
          if (bus_in[0]) done_d = 1'b0;
          if (bus_in[1]) ovr_d  = 1'b0;
        end
      endcase
    end

    case (state_q)
      S_IDLE: if (wr && addr == 2'd0) begin
        state_d = S_SETUP;
        cnt_d   = div_q;
        edge_d  = '0;
        lvl_d   = ctrl_q[7];
        rx_sh_d = '0;
        for (int i = 0; i < CHANNELS; i++) cs_n_d[i] = (ch != 3'(i));
        if (!cpha) begin
          sdo_d = lsb ? tx_ld[0] : tx_ld[15];
          tx_d  = lsb ? (tx_ld >> 1) : (tx_ld << 1);
        end else begin
          sdo_d = 1'b0;
          tx_d  = tx_ld;
        end
      end
      S_SETUP: if (expire) state_d = S_SHIFT;
      S_SHIFT: if (expire) begin
        lvl_d  = ~lvl_q;
        edge_d = edge_q + 5'd1;
        // CPHA=0 samples on leading edges, CPHA=1 on trailing edges.
        if (lead ^ cpha) begin
          rx_sh_d = lsb ? {miso, rx_sh_q[15:1]} : {rx_sh_q[14:0], miso};
        end else begin
          sdo_d = lsb ? tx_q[0] : tx_q[15];
          tx_d  = lsb ? (tx_q >> 1) : (tx_q << 1);
        end
        if (edge_q == {len_m1, 1'b1}) state_d = S_HOLD;
      end
      default: if (expire) begin
        state_d = S_IDLE;
        cs_n_d  = '1;
        done_d  = 1'b1;
        // LSB-first fills from the top; right-justify on completion.
        rx_d    = lsb ? (rx_sh_q >> (4'd15 - len_m1)) : rx_sh_q;
      end
    endcase

    // Only the active channel follows the shift level; the rest idle at CPOL.
    for (int i = 0; i < CHANNELS; i++)
      sck_d[i] = (state_d != S_IDLE && ctrl_d[6:4] == 3'(i)) ? lvl_d : ctrl_d[7];
  end

  // State and output registers; reset aborts any transfer at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      iowb_q  <= 1'b1;
      cnt_q   <= '0;
      div_q   <= DIV_W'(DIV_RESET);
      edge_q  <= '0;
      ctrl_q  <= CTRL_RESET;
      tx_q    <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
      sdo_q   <= 1'b0;
      lvl_q   <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      irq_q   <= 1'b0;
      cs_n_q  <= '1;
      sck_q   <= '0;
    end else begin
      state_q <= state_d;
      iowb_q  <= IOWb;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      ctrl_q  <= ctrl_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      sdo_q   <= sdo_d;
      lvl_q   <= lvl_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      irq_q   <= irq_d;
      cs_n_q  <= cs_n_d;
      sck_q   <= sck_d;
    end
  end

  // Read mux is combinational; the parent owns the tristate.
  always_comb begin
    case (addr)
      2'd0:    bus_out = rx_q;
      2'd1:    bus_out = {4'b0, ctrl_q};
      2'd2:    bus_out = 16'(div_q);
      default: bus_out = {13'b0, ovr_q, done_q, busy};
    endcase
  end

  assign bus_drive = io_sel && !IORb;
  assign sck       = sck_q;
  assign cs_n      = cs_n_q;
  assign sdo       = sdo_q & ~lb;
  assign irq       = irq_q;

endmodule

// File: tb/tb_spi_io_master.sv
// tb_spi_io_master: scoreboard bench for spi_io_master with an SPI slave model.
module tb_spi_io_master;
  localparam int CHANNELS = 3;
  localparam int DIV_W    = 8;

  logic                clk = 1'b0, rst = 1'b0;
  logic                io_sel = 1'b0, IOWb = 1'b1, IORb = 1'b1, sdi = 1'b0;
  logic [1:0]          addr = 2'd0;
  logic [15:0]         bus_in = 16'h0;
  logic [15:0]         bus_out;
  logic                bus_drive, sdo, irq;
  logic [CHANNELS-1:0] sck, cs_n;

  spi_io_master #(.CHANNELS(CHANNELS), .DIV_W(DIV_W), .DIV_RESET(0)) u_dut (
    .clk(clk), .rst(rst), .io_sel(io_sel), .addr(addr), .IOWb(IOWb), .IORb(IORb),
    .bus_in(bus_in), .bus_out(bus_out), .bus_drive(bus_drive), .sck(sck),
    .cs_n(cs_n), .sdo(sdo), .sdi(sdi), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rx;
    logic [15:0] mosi;
    logic        chk_mosi;
    int          busy;
    logic        chk_irq;
  } exp_t;
  exp_t sb_q[$];

  int n_run = 0, n_fail = 0;

  // slave model configuration and observations
  int                  cfg_ch = 0, cfg_len = 8;
  logic                cfg_cpha = 1'b0, cfg_lsb = 1'b0;
  logic [15:0]         pat = 16'h0, mosi = 16'h0;
  int                  e = 0;
  int                  tog [CHANNELS];
  int                  cs_fall [CHANNELS];
  logic [CHANNELS-1:0] cs_seen = '1, sck_prev = '0, cs_prev = '1;
  logic                first_sdo = 1'b0, got_first = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int bidx(input int k);
    return cfg_lsb ? k : cfg_len - 1 - k;
  endfunction

  // SPI slave: drives sdi on shift edges, captures sdo on sample edges
  initial begin
    int k;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (sck[i] != sck_prev[i]) tog[i]++;
          if (!cs_n[i] && cs_prev[i]) cs_fall[i]++;
        end
        cs_seen = cs_seen & cs_n;
        if (cfg_ch < CHANNELS) begin
          if (!cs_n[cfg_ch] && cs_prev[cfg_ch]) begin
            e = 0; mosi = '0; got_first = 1'b0;
            if (!cfg_cpha) sdi = pat[bidx(0)];
          end else if (!cs_n[cfg_ch] && sck[cfg_ch] != sck_prev[cfg_ch]) begin
            if ((e % 2 == 0) != cfg_cpha) begin
              mosi[bidx(e / 2)] = sdo;
              if (!got_first) begin first_sdo = sdo; got_first = 1'b1; end
            end else begin
              k = cfg_cpha ? e / 2 : (e + 1) / 2;
              if (k < cfg_len) sdi = pat[bidx(k)];
            end
            e++;
          end
        end
      end
      sck_prev = sck;
      cs_prev  = cs_n;
    end
  end

  task automatic clr_mon();
    for (int i = 0; i < CHANNELS; i++) begin tog[i] = 0; cs_fall[i] = 0; end
    cs_seen = '1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk); io_sel = 1'b1; addr = a; bus_in = d; IOWb = 1'b0;
    @(negedge clk); IOWb = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [15:0] exp);
    io_sel = 1'b1; addr = a; IORb = 1'b0; #1;
    chk(tag, bus_out, exp);
    IORb = 1'b1;
  endtask

  // wait for DONE with a cycle budget, then pop and compare the scoreboard
  task automatic run(input string tag);
    exp_t        x;
    logic [15:0] st;
    int          busy_n = 0, t = 0;
    io_sel = 1'b1; addr = 2'd3; IORb = 1'b0; #1;
    st = bus_out;
    while (!st[1] && t < 400) begin
      if (st[0]) busy_n++;
      t++;
      @(negedge clk); #1;
      st = bus_out;
    end
    IORb = 1'b1;
    chk({tag, "_done"}, st[1], 1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      x = sb_q.pop_front();
      if (x.chk_irq) begin
        chk({tag, "_irq_lat0"}, irq, 0);
        @(negedge clk); #1;
        chk({tag, "_irq_lat1"}, irq, 1);
      end
      if (x.busy >= 0) chk({tag, "_busy_cycles"}, busy_n, x.busy);
      rd_chk({tag, "_rx"}, 2'd0, x.rx);
      if (x.chk_mosi) chk({tag, "_mosi"}, mosi, x.mosi);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_mon();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 3'b111);
    chk("rst_sck", sck, 3'b000);
    chk("rst_sdo", sdo, 0);
    chk("rst_irq", irq, 0);
    chk("rst_bus_drive", bus_drive, 0);
    rst = 1'b0;
    rd_chk("rst_ctrl", 2'd1, 16'h0007);
    rd_chk("rst_status", 2'd3, 16'h0000);
    rd_chk("rst_div", 2'd2, 16'h0000);
    rd_chk("rst_rx", 2'd0, 16'h0000);
    IORb = 1'b0; #1; chk("rd_bus_drive", bus_drive, 1); IORb = 1'b1;

    // mode 0, channel 1, 8-bit MSB-first, DIV=0
    wr(2'd1, 16'h0017); wr(2'd2, 16'h0000);
    cfg_ch = 1; cfg_len = 8; cfg_cpha = 1'b0; cfg_lsb = 1'b0; pat = 16'h003C;
    clr_mon();
    sb_q.push_back('{rx: 16'h003C, mosi: 16'h00A5, chk_mosi: 1'b1, busy: 18, chk_irq: 1'b0});
    wr(2'd0, 16'h00A5);
    run("m0");
    chk("m0_tog0", tog[0], 0);
    chk("m0_tog1", tog[1], 16);
    chk("m0_tog2", tog[2], 0);
    chk("m0_cs_seen", cs_seen, 3'b101);
    chk("m0_cs_fall", cs_fall[1], 1);

    // mode 3, channel 0, 12-bit LSB-first, DIV=2
    wr(2'd3, 16'h0003);
    wr(2'd1, 16'h058B); wr(2'd2, 16'h0002);
    #1 chk("m3_idle_sck", sck, 3'b111);
    cfg_ch = 0; cfg_len = 12; cfg_cpha = 1'b1; cfg_lsb = 1'b1; pat = 16'h0ABC;
    clr_mon();
    sb_q.push_back('{rx: 16'h0ABC, mosi: 16'h00F1, chk_mosi: 1'b1, busy: 78, chk_irq: 1'b0});
    wr(2'd0, 16'h00F1);
    run("m3");
    chk("m3_first_sdo", first_sdo, 1);
    chk("m3_tog0", tog[0], 24);
    chk("m3_end_sck", sck, 3'b111);

    // overrun while busy, interrupt enabled
    wr(2'd3, 16'h0003);
    wr(2'd1, 16'h0207); wr(2'd2, 16'h0001);
    cfg_ch = 0; cfg_len = 8; cfg_cpha = 1'b0; cfg_lsb = 1'b0; pat = 16'h0096;
    clr_mon();
    sb_q.push_back('{rx: 16'h0096, mosi: 16'h005A, chk_mosi: 1'b1, busy: -1, chk_irq: 1'b1});
    wr(2'd0, 16'h005A);
    repeat (4) @(negedge clk);
    wr(2'd0, 16'h00FF); wr(2'd1, 16'h0000); wr(2'd2, 16'h0009);
    rd_chk("ovr_status", 2'd3, 16'h0005);
    rd_chk("ovr_ctrl_kept", 2'd1, 16'h0207);
    rd_chk("ovr_div_kept", 2'd2, 16'h0001);
    run("ovr");
    chk("ovr_cs_fall", cs_fall[0], 1);
    wr(2'd3, 16'h0003);
    rd_chk("clr_status", 2'd3, 16'h0000);
    @(negedge clk); #1 chk("clr_irq", irq, 0);

    // held write strobe gives a single transfer
    wr(2'd1, 16'h0001); wr(2'd2, 16'h0000);
    cfg_ch = 0; cfg_len = 2; cfg_cpha = 1'b0; cfg_lsb = 1'b0; pat = 16'h0002;
    clr_mon();
    @(negedge clk); io_sel = 1'b1; addr = 2'd0; bus_in = 16'h0001; IOWb = 1'b0;
    repeat (10) @(negedge clk);
    IOWb = 1'b1;
    @(negedge clk); #1;
    chk("hold_cs_fall", cs_fall[0], 1);
    rd_chk("hold_status", 2'd3, 16'h0002);
    rd_chk("hold_rx", 2'd0, 16'h0002);
    chk("hold_mosi", mosi, 16'h0001);

    // channel beyond CHANNELS: full timing, no pin activity
    wr(2'd3, 16'h0003);
    wr(2'd1, 16'h0077); wr(2'd2, 16'h0000);
    cfg_ch = 7; sdi = 1'b0;
    clr_mon();
    sb_q.push_back('{rx: 16'h0000, mosi: 16'h0000, chk_mosi: 1'b0, busy: 18, chk_irq: 1'b0});
    wr(2'd0, 16'h0033);
    run("ch7");
    for (int i = 0; i < CHANNELS; i++) chk($sformatf("ch7_tog%0d", i), tog[i], 0);
    chk("ch7_cs_seen", cs_seen, 3'b111);

    // loopback bit
    wr(2'd3, 16'h0003);
    wr(2'd1, 16'h0807);
`ifdef SPI_LOOPBACK_EN
    rd_chk("lb_ctrl", 2'd1, 16'h0807);
    cfg_ch = 0; cfg_len = 8; cfg_cpha = 1'b0; cfg_lsb = 1'b0; pat = 16'h00FF;
    clr_mon();
    sb_q.push_back('{rx: 16'h005A, mosi: 16'h0000, chk_mosi: 1'b1, busy: 18, chk_irq: 1'b0});
    wr(2'd0, 16'h005A);
    run("lb");
`else
    rd_chk("lb_ctrl_masked", 2'd1, 16'h0007);
`endif

    // reset in the middle of a 16-bit, DIV=3 transfer
    wr(2'd3, 16'h0003);
    wr(2'd1, 16'h000F); wr(2'd2, 16'h0003);
    cfg_ch = 0; cfg_len = 16; cfg_cpha = 1'b0; cfg_lsb = 1'b0; pat = 16'h0000;
    wr(2'd0, 16'h1234);
    repeat (20) @(negedge clk); #1;
    chk("mid_cs_n", cs_n, 3'b110);
    rst = 1'b1; #1;
    chk("mid_rst_cs_n", cs_n, 3'b111);
    chk("mid_rst_sck", sck, 3'b000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_chk("mid_rst_status", 2'd3, 16'h0000);
    rd_chk("mid_rst_ctrl", 2'd1, 16'h0007);
    rd_chk("mid_rst_div", 2'd2, 16'h0000);

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
